// File: rtl/tff_mod_counter_pkg.sv
// Shared constants for the modulo up/down T-stage counter.
// The optional sticky overflow flag is enabled by defining TFF_CNT_STICKY_OVF_EN.
package tff_cnt_pkg;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/tff_mod_counter_if.sv
// Control/status bundle of the modulo counter.
// The ovf signal exists only when TFF_CNT_STICKY_OVF_EN is defined.
interface tff_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
`ifdef TFF_CNT_STICKY_OVF_EN
  logic             ovf;

  modport master (output en, up, load, din, input q, tc, wrap, ovf);
  modport slave  (input en, up, load, din, output q, tc, wrap, ovf);
`else
  modport master (output en, up, load, din, input q, tc, wrap);
  modport slave  (input en, up, load, din, output q, tc, wrap);
`endif
endinterface

// File: rtl/tff_mod_counter_t_stage.sv
// Falling-edge toggle flip-flop with toggle enable and asynchronous active-low clear.
module t_stage (
  output logic q,
  input  logic t,
  input  logic clk,
  input  logic reset
);
  logic q_d;
  logic q_q;

  // toggle decision
  always_comb begin
    q_d = q_q;
    if (t) begin
      q_d = ~q_q;
    end else begin
      q_d = q_q;
    end
  end

  // storage bit, cleared asynchronously
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter whose state lives in a chain of T stages.
// Defining TFF_CNT_STICKY_OVF_EN adds a sticky wrap flag (ovf).
module tff_mod_counter
  import tff_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic            clk,
  input logic            reset,
  tff_mod_counter_if.slave bus
);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_params
    $error("tff_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // MOD_EXT is one bit wider so MODULUS == 2**WIDTH never matches a din value
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t_s;
  logic             wrap_d;
  logic             wrap_q;

  // next count and wrap detection; load beats enable
  always_comb begin
    q_d    = q_s;
    wrap_d = 1'b0;
    if (bus.load) begin
      if ({1'b0, bus.din} >= MOD_EXT) begin
        q_d = MAX_Q;
      end else begin
        q_d = bus.din;
      end
    end else if (bus.en) begin
      if (bus.up == DIR_UP) begin
        if (q_s == MAX_Q) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_s + WIDTH'(1);
        end
      end else begin
        if (q_s == '0) begin
          q_d    = MAX_Q;
          wrap_d = 1'b1;
        end else begin
          q_d = q_s - WIDTH'(1);
        end
      end
    end else begin
      q_d = q_s;
    end
  end

  assign t_s = q_s ^ q_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    t_stage u_stage (
      .q     (q_s[i]),
      .t     (t_s[i]),
      .clk   (clk),
      .reset (reset)
    );
  end

  // one-cycle wrap pulse
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

`ifdef TFF_CNT_STICKY_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // sticky flag: set by any wrap, cleared only by load or reset
  always_comb begin
    ovf_d = ovf_q;
    if (bus.load) begin
      ovf_d = 1'b0;
    end else if (wrap_d) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // sticky flag register
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.q    = q_s;
  assign bus.wrap = wrap_q;
  assign bus.tc   = (bus.up == DIR_UP) ? (q_s == MAX_Q) : (q_s == '0);

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for tff_mod_counter (WIDTH=4, MODULUS=10); ovf checks run
// when TFF_CNT_STICKY_OVF_EN is defined.
module tb_tff_mod_counter;
  import tff_cnt_pkg::*;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  tff_mod_counter_if #(.WIDTH(W)) bus ();

  tff_mod_counter #(.WIDTH(W), .MODULUS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int eq, input int ewrap, input int etc);
    chk({tag, ".q"},    32'(bus.q),    32'(eq));
    chk({tag, ".wrap"}, 32'(bus.wrap), 32'(ewrap));
    chk({tag, ".tc"},   32'(bus.tc),   32'(etc));
  endtask

  // one active (falling) edge, then settle away from it
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    bus.load = 1'b1;
    bus.din  = W'(v);
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    int exp_dn[6];
    exp_dn = '{3, 2, 1, 0, 9, 8};

    reset    = 1'b0;
    bus.en   = 1'b0;
    bus.up   = DIR_UP;
    bus.load = 1'b0;
    bus.din  = '0;

    // 1: reset state, release at t=7, count up 12 edges
    #6;
    chk_out("rst", 0, 0, 0);
`ifdef TFF_CNT_STICKY_OVF_EN
    chk("rst.ovf", 32'(bus.ovf), 32'd0);
`endif
    #1;
    reset  = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_out($sformatf("up%0d", i), (i + 1) % 10, (i == 9) ? 1 : 0, (((i + 1) % 10) == 9) ? 1 : 0);
    end

    // 2: load 4 with en=1 (load wins), then count down 6 edges
    bus.up = DIR_DOWN;
    do_load(4);
    chk_out("ld4", 4, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("dn%0d", i), exp_dn[i], (exp_dn[i] == 9) ? 1 : 0, (exp_dn[i] == 0) ? 1 : 0);
    end

    // 3: clamping of out-of-range load values
    bus.en = 1'b0;
    do_load(13);
    chk_out("ld13", 9, 0, 0);
    do_load(3);
    do_load(10);
    chk_out("ld10", 9, 0, 0);

    // 4: hold with en=0
    bus.up = DIR_UP;
    do_load(7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("hold%0d", i), 7, 0, 0);
    end

    // wrap pulse lasts one cycle once enable drops
    do_load(9);
    bus.en = 1'b1;
    step();
    chk_out("wrap9", 0, 1, 0);
    bus.en = 1'b0;
    step();
    chk_out("wrapclr", 0, 0, 0);

    // direction change: tc follows up immediately
    bus.up = DIR_DOWN;
    #1;
    chk("tc_dir", 32'(bus.tc), 32'd1);
    bus.up = DIR_UP;

    // 5: reset mid-count between edges
    do_load(4);
    bus.en = 1'b1;
    step();
    chk("pre_rst.q", 32'(bus.q), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0);
    step();
    chk_out("rst_held", 0, 0, 0);
    reset  = 1'b1;
    bus.en = 1'b0;
    step();
    chk_out("rst_rel", 0, 0, 0);

`ifdef TFF_CNT_STICKY_OVF_EN
    // 6: sticky overflow
    do_load(8);
    chk("ovf.ld8", 32'(bus.ovf), 32'd0);
    bus.en = 1'b1;
    step();
    chk("ovf.q9", 32'(bus.ovf), 32'd0);
    step();
    chk("ovf.wrap", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("ovf.stay%0d", i), 32'(bus.ovf), 32'd1);
    end
    bus.en = 1'b0;
    do_load(2);
    chk("ovf.clr", 32'(bus.ovf), 32'd0);
    chk("ovf.q2", 32'(bus.q), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
